// File: rtl/inc_chk_pkg.sv
// inc_chk_pkg: field offsets and state encoding shared by the inc_chk checker.
// Control word is {width, height, 4'h0}; pixel beat is {y[7:0], x[15:0]}.
package inc_chk_pkg;

    localparam int DIM_W = 16;

    localparam int WIDTH_MSB  = 35;
    localparam int WIDTH_LSB  = 20;
    localparam int HEIGHT_MSB = 19;
    localparam int HEIGHT_LSB = 4;
    localparam int RSVD_MSB   = 3;
    localparam int RSVD_LSB   = 0;

    localparam int X_MSB = 15;
    localparam int X_LSB = 0;
    localparam int Y_MSB = 23;
    localparam int Y_LSB = 16;

    typedef enum logic {
        WAIT_CTRL = 1'b0,
        CHECK     = 1'b1
    } state_e;

endpackage

// File: rtl/inc_chk_pos.sv
// inc_chk_pos: loadable expected raster coordinate counter.
// Wraps x at width-1 and y at height-1; can restart from a received coordinate.
module inc_chk_pos
    import inc_chk_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    input  logic             adv_i,
    input  logic             resync_i,
    input  logic [DIM_W-1:0] rx_i,
    input  logic [7:0]       ry_i,
    output logic [DIM_W-1:0] exp_x_o,
    output logic [DIM_W-1:0] exp_y_o,
    output logic             last_pixel_o
);

    logic [DIM_W-1:0] width_q, height_q, x_q, y_q;
    logic [DIM_W-1:0] x_d, y_d;
    logic [DIM_W-1:0] w, h, bx, by, ry_full;
    logic             x_end, y_end, jump;

    assign w       = load_i ? width_i  : width_q;
    assign h       = load_i ? height_i : height_q;
    assign exp_x_o = load_i ? '0 : x_q;
    assign exp_y_o = load_i ? '0 : y_q;
    assign ry_full = {exp_y_o[DIM_W-1:8], ry_i};

    // out-of-range data is corruption, not a skip: keep own count then
    assign jump = resync_i && (rx_i < w) && (ry_full < h);
    assign bx   = jump ? rx_i    : exp_x_o;
    assign by   = jump ? ry_full : exp_y_o;

    assign x_end        = (bx >= w - 1'b1);
    assign y_end        = (by >= h - 1'b1);
    assign last_pixel_o = x_end && y_end;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (adv_i) begin
            x_d = x_end ? '0 : bx + 1'b1;
            y_d = x_end ? (y_end ? '0 : by + 1'b1) : by;
        end else if (load_i) begin
            x_d = '0;
            y_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            width_q  <= '0;
            height_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            if (load_i) begin
                width_q  <= width_i;
                height_q <= height_i;
            end
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/inc_chk.sv
// inc_chk: incrementing-pattern sink, checks each pixel against its raster position.
// INC_CHK_RESYNC_EN: after a mismatch, continue from the received coordinate.
module inc_chk
    import inc_chk_pkg::*;
#(
    parameter int STALL_PERIOD = 0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             control_valid,
    input  logic [35:0]      control_data,
    input  logic             video_valid,
    input  logic [23:0]      video_data,
    input  logic             err_clr,
    output logic             sink_ready,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky,
    output logic             ctrl_err,
    output logic             short_frame
);

    localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_PERIOD - 1);

    state_e           state_q;
    logic [SW-1:0]    stall_q, stall_nx;
    logic             sink_ready_q, frame_done_q, err_sticky_q;
    logic             ctrl_err_q, short_frame_q, mid_q;
    logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

    logic [DIM_W-1:0] ctrl_w, ctrl_h, exp_x, exp_y;
    logic             ctrl_bad, ctrl_ok, ctrl_rej;
    logic             beat, mismatch, resync, last;
    logic             unused_bits;

    assign ctrl_w   = control_data[WIDTH_MSB:WIDTH_LSB];
    assign ctrl_h   = control_data[HEIGHT_MSB:HEIGHT_LSB];
    assign ctrl_bad = (ctrl_w == '0) || (ctrl_h == '0);
    assign ctrl_ok  = control_valid && !ctrl_bad;
    assign ctrl_rej = control_valid && ctrl_bad;

    // a beat alongside a good control word is pixel (0,0) of the new frame
    assign beat = video_valid &&
                  ((state_q == CHECK && !control_valid) || ctrl_ok);

    assign mismatch = beat &&
        ((video_data[X_MSB:X_LSB] != exp_x) ||
         (video_data[Y_MSB:Y_LSB] != exp_y[7:0]));

`ifdef INC_CHK_RESYNC_EN
    assign resync = mismatch;
`else
    assign resync = 1'b0;
`endif

    assign unused_bits = ^{exp_y[DIM_W-1:8],
                           control_data[RSVD_MSB:RSVD_LSB]};

    inc_chk_pos u_pos (
        .clk          (clk),
        .rst          (rst),
        .load_i       (ctrl_ok),
        .width_i      (ctrl_w),
        .height_i     (ctrl_h),
        .adv_i        (beat),
        .resync_i     (resync),
        .rx_i         (video_data[X_MSB:X_LSB]),
        .ry_i         (video_data[Y_MSB:Y_LSB]),
        .exp_x_o      (exp_x),
        .exp_y_o      (exp_y),
        .last_pixel_o (last)
    );

    assign stall_nx = (stall_q == STALL_LAST) ? '0 : stall_q + 1'b1;

    function automatic logic ready_at(input logic [SW-1:0] c);
        return (STALL_PERIOD == 0) || (c != STALL_LAST);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= WAIT_CTRL;
            stall_q       <= '0;
            sink_ready_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
            err_sticky_q  <= 1'b0;
            ctrl_err_q    <= 1'b0;
            short_frame_q <= 1'b0;
            mid_q         <= 1'b0;
        end else begin
            frame_done_q  <= beat && last;
            ctrl_err_q    <= ctrl_rej;
            short_frame_q <= ctrl_ok && (state_q == CHECK) && mid_q;

            if (beat) begin
                mid_q <= !last;
            end else if (control_valid) begin
                mid_q <= 1'b0;
            end

            if (beat && last) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end

            if (err_clr) begin
                err_cnt_q    <= '0;
                err_sticky_q <= 1'b0;
            end else if (mismatch) begin
                err_sticky_q <= 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end

            unique case (state_q)
                WAIT_CTRL: begin
                    if (ctrl_ok) begin
                        state_q      <= CHECK;
                        stall_q      <= '0;
                        sink_ready_q <= ready_at('0);
                    end
                end
                CHECK: begin
                    if (ctrl_rej) begin
                        state_q      <= WAIT_CTRL;
                        sink_ready_q <= 1'b0;
                    end else begin
                        stall_q      <= stall_nx;
                        sink_ready_q <= ready_at(stall_nx);
                    end
                end
                default: begin
                    state_q      <= WAIT_CTRL;
                    sink_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign sink_ready  = sink_ready_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign err_sticky  = err_sticky_q;
    assign ctrl_err    = ctrl_err_q;
    assign short_frame = short_frame_q;

endmodule

// File: tb/tb_inc_chk.sv
// tb_inc_chk: directed bench for inc_chk with a reference model feeding a scoreboard.
// Built with STALL_PERIOD=3; error totals follow INC_CHK_RESYNC_EN.
module tb_inc_chk;

    localparam int CNT_W = 16;
    localparam int SP    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             control_valid = 1'b0;
    logic [35:0]      control_data  = '0;
    logic             video_valid   = 1'b0;
    logic [23:0]      video_data    = '0;
    logic             err_clr       = 1'b0;
    logic             sink_ready, frame_done, err_sticky, ctrl_err, short_frame;
    logic [CNT_W-1:0] frame_cnt, err_cnt;

    always #5 clk = ~clk;

    inc_chk #(.STALL_PERIOD(SP), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .control_valid (control_valid),
        .control_data  (control_data),
        .video_valid   (video_valid),
        .video_data    (video_data),
        .err_clr       (err_clr),
        .sink_ready    (sink_ready),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt),
        .err_sticky    (err_sticky),
        .ctrl_err      (ctrl_err),
        .short_frame   (short_frame)
    );

    typedef struct packed {
        logic             rdy, fd, ce, sf, st;
        logic [CNT_W-1:0] fc, ec;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    bit m_chk, m_st;
    int m_w, m_h, m_x, m_y, m_fc, m_ec, m_scnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_chk = 0; m_st = 0; m_w = 0; m_h = 0; m_x = 0; m_y = 0;
        m_fc = 0; m_ec = 0; m_scnt = 0;
    endtask

    task automatic model(input bit cv, input logic [35:0] cd, input bit vv,
                         input logic [23:0] vd, input bit clr,
                         output exp_t e);
        int  w, h, bx, by;
        bit  bad, ok, beat, mism;
        e = '0;
        w = int'(cd[35:20]);
        h = int'(cd[19:4]);
        bad  = cv && (w == 0 || h == 0);
        ok   = cv && !bad;
        beat = vv && ((m_chk && !cv) || ok);
        if (ok) begin
            e.sf = m_chk && (m_x != 0 || m_y != 0);
            if (!m_chk) begin
                m_chk = 1; m_scnt = 0;
            end else begin
                m_scnt = (m_scnt + 1) % SP;
            end
            m_w = w; m_h = h; m_x = 0; m_y = 0;
        end else if (bad) begin
            e.ce = 1;
            m_chk = 0;
        end else if (m_chk) begin
            m_scnt = (m_scnt + 1) % SP;
        end
        if (beat) begin
            mism = (int'(vd[15:0]) != m_x) || (vd[23:16] != m_y[7:0]);
            bx = m_x; by = m_y;
`ifdef INC_CHK_RESYNC_EN
            if (mism && int'(vd[15:0]) < m_w &&
                ((m_y & 32'hff00) | int'(vd[23:16])) < m_h) begin
                bx = int'(vd[15:0]);
                by = (m_y & 32'hff00) | int'(vd[23:16]);
            end
`endif
            if (bx == m_w - 1 && by == m_h - 1) begin
                m_x = 0; m_y = 0; m_fc++; e.fd = 1;
            end else if (bx == m_w - 1) begin
                m_x = 0; m_y = by + 1;
            end else begin
                m_x = bx + 1; m_y = by;
            end
            if (mism) begin
                m_st = 1;
                if (m_ec != 32'hffff) m_ec++;
            end
        end
        if (clr) begin
            m_ec = 0; m_st = 0;
        end
        e.fc  = CNT_W'(m_fc);
        e.ec  = CNT_W'(m_ec);
        e.st  = m_st;
        e.rdy = m_chk && (m_scnt != SP - 1);
    endtask

    task automatic step(input bit cv, input logic [35:0] cd, input bit vv,
                        input logic [23:0] vd, input bit clr);
        exp_t e;
        control_valid = cv; control_data = cd;
        video_valid = vv; video_data = vd; err_clr = clr;
        model(cv, cd, vv, vd, clr, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        control_valid = 0; video_valid = 0; err_clr = 0;
        e = sb.pop_front();
        chk("sink_ready", 32'(sink_ready), 32'(e.rdy));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
        chk("err_cnt", 32'(err_cnt), 32'(e.ec));
        chk("err_sticky", 32'(err_sticky), 32'(e.st));
        chk("ctrl_err", 32'(ctrl_err), 32'(e.ce));
        chk("short_frame", 32'(short_frame), 32'(e.sf));
    endtask

    function automatic logic [35:0] cw(input int w, input int h);
        return {w[15:0], h[15:0], 4'h0};
    endfunction

    function automatic logic [23:0] px(input int x, input int y);
        return {y[7:0], x[15:0]};
    endfunction

    task automatic pix(input int x, input int y);
        step(0, '0, 1, px(x, y), 0);
    endtask

    task automatic ctrl(input int w, input int h);
        step(1, cw(w, h), 0, '0, 0);
    endtask

    task automatic idle(input bit clr);
        step(0, '0, 0, '0, clr);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_rdy"}, 32'(sink_ready), 0);
        chk({tag, "_fd"}, 32'(frame_done), 0);
        chk({tag, "_fc"}, 32'(frame_cnt), 0);
        chk({tag, "_ec"}, 32'(err_cnt), 0);
        chk({tag, "_st"}, 32'(err_sticky), 0);
        chk({tag, "_ce"}, 32'(ctrl_err), 0);
        chk({tag, "_sf"}, 32'(short_frame), 0);
    endtask

    initial begin
        int lows;
        int k;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        all_zero("reset");
        rst = 1;

        pix(0, 0);
        pix(1, 0);

        ctrl(0, 4);
        chk("wzero_ctrl_err", 32'(ctrl_err), 1);
        pix(0, 0);
        chk("wzero_ready", 32'(sink_ready), 0);
        chk("wzero_no_err", 32'(err_cnt), 0);

        ctrl(64, 32);
        chk("ready_rise", 32'(sink_ready), 1);
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 64; x++)
                pix(x, y);
        chk("big_done", 32'(frame_done), 1);
        chk("big_fcnt", 32'(frame_cnt), 1);
        chk("big_err", 32'(err_cnt), 0);
        idle(0);
        chk("big_done_pulse", 32'(frame_done), 0);

        ctrl(4, 2);
        k = 0;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) begin
                pix((k == 2) ? 5 : x, y);
                k++;
            end
        chk("corrupt_err", 32'(err_cnt), 1);
        chk("corrupt_sticky", 32'(err_sticky), 1);
        chk("corrupt_fcnt", 32'(frame_cnt), 2);

        idle(1);
        ctrl(4, 2);
        k = 0;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) begin
                if (k != 1) pix(x, y);
                k++;
            end
`ifdef INC_CHK_RESYNC_EN
        chk("drop_err", 32'(err_cnt), 1);
        chk("drop_fdone", 32'(frame_done), 1);
`else
        chk("drop_err", 32'(err_cnt), 6);
        chk("drop_fdone", 32'(frame_done), 0);
`endif

        idle(1);
        ctrl(4, 4);
        for (int i = 0; i < 5; i++) pix(i % 4, i / 4);
        ctrl(2, 2);
        chk("short_pulse", 32'(short_frame), 1);
        pix(0, 0);
        pix(1, 0);
        pix(0, 1);
        chk("short_not_yet", 32'(frame_done), 0);
        pix(1, 1);
        chk("short_done", 32'(frame_done), 1);
        chk("short_err", 32'(err_cnt), 0);

        step(1, cw(3, 1), 1, px(0, 0), 0);
        chk("simul_no_short", 32'(short_frame), 0);
        pix(1, 0);
        pix(2, 0);
        chk("simul_done", 32'(frame_done), 1);
        chk("simul_err", 32'(err_cnt), 0);

        ctrl(2, 2);
        pix(7, 7);
        chk("clr_pre_err", 32'(err_cnt), 1);
        step(0, '0, 1, px(7, 7), 1);
        chk("clr_wins_cnt", 32'(err_cnt), 0);
        chk("clr_wins_st", 32'(err_sticky), 0);

        lows = 0;
        for (int i = 0; i < 9; i++) begin
            idle(0);
            if (!sink_ready) lows++;
        end
        chk("stall_lows", 32'(lows), 3);

        pix(0, 1);
        #2 rst = 0;
        #1;
        all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        pix(0, 0);
        chk("post_rst_ready", 32'(sink_ready), 0);

        ctrl(2, 2);
        pix(0, 0);
        step(1, cw(0, 0), 1, px(1, 0), 0);
        chk("rej_in_check", 32'(ctrl_err), 1);
        chk("rej_ready", 32'(sink_ready), 0);
        pix(1, 0);
        chk("rej_ignored", 32'(err_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inc_chk.md
# inc_chk

Incrementing-pattern checker that sits directly downstream of the incrementing test-pattern generator. It captures the frame-dimension control word, requests pixels from the generator, and compares every received pixel against the expected raster coordinate. It reports frames completed, mismatches and malformed frames. Used as the sink in pattern loopback benches and on-chip self-test.

## Interface
Parameters:
- STALL_PERIOD, 0: when non-zero, sink_ready drops for 1 cycle every STALL_PERIOD cycles in CHECK; 0 = no stalls.
- CNT_W, 16: width of frame_cnt and err_cnt.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- control_valid  in  1  one-cycle pulse qualifying control_data.
- control_data  in  36  {width[15:0], height[15:0], 4'h0}.
- video_valid  in  1  pixel beat present.
- video_data  in  24  {y[7:0], x[15:0]}.
- err_clr  in  1  synchronous clear of err_cnt and err_sticky.
- sink_ready  out  1  pixel request to upstream.
- frame_done  out  1  one-cycle pulse after last pixel of a frame.
- frame_cnt  out  CNT_W  completed frames, wraps.
- err_cnt  out  CNT_W  pixel mismatches, saturates at all-ones.
- err_sticky  out  1  set on any mismatch until err_clr.
- ctrl_err  out  1  one-cycle pulse, rejected control word.
- short_frame  out  1  one-cycle pulse, control word arrived mid-frame.

## Operation
- States: WAIT_CTRL (reset), CHECK.
- WAIT_CTRL: sink_ready=0; video_valid beats ignored, not counted. On control_valid: width=0 or height=0 -> ctrl_err, stay; otherwise latch dims, exp_x=exp_y=0, go CHECK.
- CHECK: sink_ready=1 except stall cycles. Handshake: upstream answers a ready with data one cycle later, so every cycle with video_valid=1 is an accepted beat regardless of current sink_ready.
- Compare: video_data[15:0] vs exp_x, video_data[23:16] vs exp_y[7:0]. Mismatch -> err_cnt+1 (saturating), err_sticky=1.
- Advance per beat: exp_x+1; at exp_x=width-1 -> exp_x=0, exp_y+1; at (width-1, height-1) -> exp_x=exp_y=0, frame_cnt+1, frame_done.
- control_valid in CHECK: re-validate as above; if valid and (exp_x,exp_y)≠(0,0) pulse short_frame; reload dims, reset position. Invalid word -> ctrl_err, return to WAIT_CTRL.
- Simultaneous control_valid and video_valid: control applied first; that beat checked as pixel (0,0) of the new dims.
- err_clr and a mismatch in the same cycle: clear wins, err_cnt=0, err_sticky=0.

## Timing
- All outputs registered; reset values: sink_ready=0, frame_done=0, frame_cnt=0, err_cnt=0, err_sticky=0, ctrl_err=0, short_frame=0; state WAIT_CTRL.
- sink_ready rises the cycle after an accepted control_valid.
- Compare result visible on err_cnt/err_sticky 1 cycle after the beat; frame_done high 1 cycle after the last beat.
- Stall counter free-runs only in CHECK, resets on entry.
- Reset mid-frame: all state cleared immediately (async); a new control word is required.

## Configuration
- INC_CHK_RESYNC_EN defined: on mismatch, next expected position = received (x,y)+1 with normal wrap, so one dropped pixel costs one error. Received y is 8 bits; exp_y upper bits retained.
- Undefined: expected position always advances from its own count; a dropped pixel produces errors to end of frame.

## Structure
- Shared package: control_data field offsets (WIDTH_MSB=35, HEIGHT_MSB=19, RSVD 3:0), pixel field offsets (X 15:0, Y 23:16), state encodings.
- One sub-module, inc_chk_pos: loadable expected-coordinate counter (load, advance, width/height, outputs exp_x, exp_y, last_pixel).

## Test plan
- Control 1920x1080, continuous correct stream -> frame_done after beat 2073600, frame_cnt=1, err_cnt=0.
- Control 4x2, corrupt beat 3 (x=5) -> err_cnt=1, err_sticky=1; with RESYNC_EN total errors=1, without also 1 (x only value wrong).
- Control 4x2, drop beat 2 -> RESYNC_EN: err_cnt=1; not defined: err_cnt=6.
- Control width=0 -> ctrl_err pulse, sink_ready stays 0, beats ignored.
- Control 4x4, new control 2x2 after 5 beats -> short_frame pulse, next beat checked as (0,0), frame_done after 4 more beats.
- STALL_PERIOD=3 -> sink_ready low 1 of every 3 cycles; err_clr with simultaneous mismatch -> err_cnt=0, err_sticky=0; async reset mid-frame -> all outputs 0, WAIT_CTRL.
